cachepool_l2_chan_demux: RTL

// - Sits between one L1 cache-controller refill port (l2 reqrsp bus) and the NumChannels L2/DRAM channels.
// - Steers each request to a channel by address interleave; optionally compacts the address for that channel.
// - Returns responses to the controller in request order, using an order FIFO of channel indices.

---
 rtl/cachepool_l2_chan_demux.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cachepool_l2_chan_demux.sv
// Routes one L1 refill reqrsp port onto NumChannels L2 channels by address interleave and
// returns responses in request order. Define CACHEPOOL_L2_SCRAMBLE_EN to strip channel bits from the address.
module cachepool_l2_chan_demux #(
  parameter int unsigned NumChannels     = 4,
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned DataWidth       = 128,
  parameter int unsigned UserWidth       = 16,
  parameter int unsigned InterleaveBytes = 16384,
  parameter int unsigned MaxOutstanding  = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               q_valid_i,
  output logic                               q_ready_o,
  input  logic [AddrWidth-1:0]               q_addr_i,
  input  logic                               q_write_i,
  input  logic [DataWidth-1:0]               q_data_i,
  input  logic [DataWidth/8-1:0]             q_strb_i,
  input  logic [UserWidth-1:0]               q_user_i,
  output logic                               p_valid_o,
  input  logic                               p_ready_i,
  output logic [DataWidth-1:0]               p_data_o,
  output logic [UserWidth-1:0]               p_user_o,
  output logic [NumChannels-1:0]             ch_q_valid_o,
  input  logic [NumChannels-1:0]             ch_q_ready_i,
  output logic [NumChannels*AddrWidth-1:0]   ch_q_addr_o,
  output logic [NumChannels-1:0]             ch_q_write_o,
  output logic [NumChannels*DataWidth-1:0]   ch_q_data_o,
  output logic [NumChannels*DataWidth/8-1:0] ch_q_strb_o,
  output logic [NumChannels*UserWidth-1:0]   ch_q_user_o,
  input  logic [NumChannels-1:0]             ch_p_valid_i,
  output logic [NumChannels-1:0]             ch_p_ready_o,
  input  logic [NumChannels*DataWidth-1:0]   ch_p_data_i,
  input  logic [NumChannels*UserWidth-1:0]   ch_p_user_i
);

  localparam int unsigned SelW = $clog2(NumChannels);
  localparam int unsigned OffW = $clog2(InterleaveBytes);
  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = PtrW + 1;

  logic [SelW-1:0]      sel;
  logic [SelW-1:0]      head;
  logic [SelW-1:0]      fifo_q [MaxOutstanding];
  logic [SelW-1:0]      fifo_d [MaxOutstanding];
  logic [PtrW-1:0]      wptr_q, wptr_d;
  logic [PtrW-1:0]      rptr_q, rptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 full, empty, push, pop;
  logic [AddrWidth-1:0] addr_out;

  assign sel   = q_addr_i[OffW +: SelW];
  assign head  = fifo_q[rptr_q];
  assign full  = (count_q == CntW'(MaxOutstanding));
  assign empty = (count_q == '0);

`ifdef CACHEPOOL_L2_SCRAMBLE_EN
  assign addr_out = {{SelW{1'b0}}, q_addr_i[AddrWidth-1:OffW+SelW], q_addr_i[OffW-1:0]};
`else
  assign addr_out = q_addr_i;
`endif

  assign ch_q_addr_o  = {NumChannels{addr_out}};
  assign ch_q_write_o = {NumChannels{q_write_i}};
  assign ch_q_data_o  = {NumChannels{q_data_i}};
  assign ch_q_strb_o  = {NumChannels{q_strb_i}};
  assign ch_q_user_o  = {NumChannels{q_user_i}};

  // Full is strict so that q_ready_o never sees p_ready_i.
  always_comb begin
    ch_q_valid_o      = '0;
    ch_q_valid_o[sel] = q_valid_i & ~full;
    q_ready_o         = ch_q_ready_i[sel] & ~full;
    ch_p_ready_o      = '0;
    if (!empty) ch_p_ready_o[head] = p_ready_i;
    p_valid_o = ~empty & ch_p_valid_i[head];
    p_data_o  = '0;
    p_user_o  = '0;
    if (!empty) begin
      p_data_o = ch_p_data_i[head*DataWidth +: DataWidth];
      p_user_o = ch_p_user_i[head*UserWidth +: UserWidth];
    end
  end

  assign push = q_valid_i & q_ready_o;
  assign pop  = p_valid_o & p_ready_i;

  always_comb begin
    fifo_d  = fifo_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};
    if (push) begin
      fifo_d[wptr_q] = sel;
      wptr_d         = wptr_q + PtrW'(1);
    end
    if (pop) rptr_d = rptr_q + PtrW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      fifo_q  <= fifo_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

`ifndef SYNTHESIS
  logic [NumChannels-1:0] in_fifo;

  always_comb begin
    in_fifo = '0;
    for (int i = 0; i < MaxOutstanding; i++) begin
      if (CntW'(i) < count_q) in_fifo[fifo_q[PtrW'(rptr_q + PtrW'(i))]] = 1'b1;
    end
  end

  a_no_stray_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
    (ch_p_valid_i & ~in_fifo) == '0);

  a_q_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (q_valid_i && !q_ready_o) |=> (q_valid_i && $stable(q_addr_i) && $stable(q_write_i)
      && $stable(q_data_i) && $stable(q_strb_i) && $stable(q_user_i)));
`endif

endmodule
